laplace_cross_window: RTL and testbench

Raster-to-window stage directly upstream of the 5-point Laplacian approximation filter (`laplace9_aprox_5`). It accepts an 8-bit grayscale image one pixel per valid cycle in row-major order. It buffers the two previous rows and presents the cross neighbourhood b, d, e, f, h for every interior output position, so a frame of IMG_W×IMG_H produces (IMG_W−2)×(IMG_H−2) windows (510×510 for the 512×512 image).

---
 rtl/laplace_pkg.sv | 30 +++
 rtl/laplace_cross_window_if.sv | 57 +++++
 rtl/laplace_line_buf.sv | 34 +++
 rtl/laplace_cross_window.sv | 163 ++++++++++++++++
 tb/tb_laplace_cross_window.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laplace_pkg.sv
// laplace_pkg: shared types and constants for the Laplacian window stage,
// the downstream laplace9_aprox_5 filter and their benches.
//   PIX_W              pixel width in bits
//   IMG_W_DEF/IMG_H_DEF default frame geometry (512x512)
//   pixel_t            one grayscale pixel
//   window_t           cross neighbourhood {b, d, e, f, h}
package laplace_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned IMG_W_DEF = 512;
  localparam int unsigned IMG_H_DEF = 512;

  typedef logic [PIX_W-1:0] pixel_t;

  // b = north, d = west, e = centre, f = east, h = south
  typedef struct packed {
    pixel_t b;
    pixel_t d;
    pixel_t e;
    pixel_t f;
    pixel_t h;
  } window_t;

  // Number of interior windows produced by one frame.
  function automatic int unsigned win_count(input int unsigned img_w,
                                            input int unsigned img_h);
    return (img_w - 2) * (img_h - 2);
  endfunction

endpackage

// File: rtl/laplace_cross_window_if.sv
// laplace_cross_window_if: pixel stream in, cross window out.
//   master : drives sof/pix_valid/pix_in, receives the window signals
//   slave  : the window stage itself
// Signals:
//   sof, pix_valid, pix_in          raster input, no backpressure
//   b, d, e, f, h                   cross neighbourhood
//   win_valid, frame_done           window strobe / last window of frame
//   win_row, win_col                window coordinates (LAPLACE_WIN_COORD_EN only)
// Optional feature macro: LAPLACE_WIN_COORD_EN
interface laplace_cross_window_if
  import laplace_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic   sof;
  logic   pix_valid;
  pixel_t pix_in;

  pixel_t b;
  pixel_t d;
  pixel_t e;
  pixel_t f;
  pixel_t h;
  logic   win_valid;
  logic   frame_done;

`ifdef LAPLACE_WIN_COORD_EN
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;

  modport master (
    output sof, pix_valid, pix_in,
    input  b, d, e, f, h, win_valid, frame_done, win_row, win_col
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output b, d, e, f, h, win_valid, frame_done, win_row, win_col
  );
`else
  modport master (
    output sof, pix_valid, pix_in,
    input  b, d, e, f, h, win_valid, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output b, d, e, f, h, win_valid, frame_done
  );
`endif

endinterface

// File: rtl/laplace_line_buf.sv
// laplace_line_buf: one image row of storage, single port, read-before-write.
// The read is combinational from the addressed entry, so in a cycle with
// en=1 rd_data_c returns the old contents while wr_data lands on the edge.
// Contents are deliberately not reset.
//   clk        clock
//   en         access strobe (write on the rising edge)
//   addr       column index
//   wr_data    value stored at addr
//   rd_data_c  current contents of addr
module laplace_line_buf
  import laplace_pkg::*;
#(
  parameter  int unsigned DEPTH  = IMG_W_DEF,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  pixel_t            wr_data,
  output pixel_t            rd_data_c
);

  pixel_t mem [DEPTH];

  assign rd_data_c = mem[addr];

  // Row storage write port
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/laplace_cross_window.sv
// laplace_cross_window: raster-to-window stage ahead of laplace9_aprox_5.
// Buffers the two previous rows and emits the 5-point cross b,d,e,f,h for
// every interior position, one cycle after the completing pixel.
//   clk, rst_n  clock, asynchronous active-low reset
//   win_if      laplace_cross_window_if.slave (pixel stream in, window out)
// Parameters: IMG_W, IMG_H (>= 3); pixel width is laplace_pkg::PIX_W.
// Optional feature macro: LAPLACE_WIN_COORD_EN adds win_row/win_col.
module laplace_cross_window
  import laplace_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  laplace_cross_window_if.slave         win_if
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic             acc;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic             win_hit_c;
  logic             last_c;

  pixel_t  lb1_rd;
  pixel_t  lb2_rd;
  pixel_t  cur_d1;
  pixel_t  lb1_d1;
  pixel_t  lb1_d2;
  pixel_t  lb2_d1;

  window_t win_q;
  logic    win_valid_q;
  logic    frame_done_q;

  assign acc = win_if.pix_valid;

  // Position of the pixel on the bus; sof forces (0,0).
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (win_if.sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  // Raster counter advance and window qualification
  always_comb begin
    col_nxt   = col_q;
    row_nxt   = row_q;
    last_c    = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
    win_hit_c = acc && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    if (acc) begin
      if (cur_col == COL_W'(IMG_W - 1)) begin
        col_nxt = '0;
        row_nxt = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : ROW_W'(cur_row + ROW_W'(1));
      end else begin
        col_nxt = COL_W'(cur_col + COL_W'(1));
        row_nxt = cur_row;
      end
    end
  end

  // Raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_nxt;
      row_q <= row_nxt;
    end
  end

  // LB1 holds row R-1; its old entry cascades into LB2 (row R-2).
  laplace_line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk       (clk),
    .en        (acc),
    .addr      (cur_col),
    .wr_data   (win_if.pix_in),
    .rd_data_c (lb1_rd)
  );

  laplace_line_buf #(.DEPTH(IMG_W)) u_lb2 (
    .clk       (clk),
    .en        (acc),
    .addr      (cur_col),
    .wr_data   (lb1_rd),
    .rd_data_c (lb2_rd)
  );

  // Tap chains: current row {pix_in, cur_d1}, LB1 {lb1_rd, lb1_d1, lb1_d2},
  // LB2 {lb2_rd, lb2_d1}. Stale taps across a row boundary are harmless
  // because no window is taken for columns 0 and 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_d1 <= '0;
      lb1_d1 <= '0;
      lb1_d2 <= '0;
      lb2_d1 <= '0;
    end else if (acc) begin
      cur_d1 <= win_if.pix_in;
      lb1_d1 <= lb1_rd;
      lb1_d2 <= lb1_d1;
      lb2_d1 <= lb2_rd;
    end
  end

  // Window output register; values hold between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= win_hit_c;
      frame_done_q <= win_hit_c && last_c;
      if (win_hit_c) begin
        win_q.b <= lb2_d1;
        win_q.d <= lb1_d2;
        win_q.e <= lb1_d1;
        win_q.f <= lb1_rd;
        win_q.h <= cur_d1;
      end
    end
  end

  assign win_if.b          = win_q.b;
  assign win_if.d          = win_q.d;
  assign win_if.e          = win_q.e;
  assign win_if.f          = win_q.f;
  assign win_if.h          = win_q.h;
  assign win_if.win_valid  = win_valid_q;
  assign win_if.frame_done = frame_done_q;

`ifdef LAPLACE_WIN_COORD_EN
  logic [ROW_W-1:0] win_row_q;
  logic [COL_W-1:0] win_col_q;

  // Window coordinates, registered alongside b..h
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (win_hit_c) begin
      win_row_q <= ROW_W'(cur_row - ROW_W'(2));
      win_col_q <= COL_W'(cur_col - COL_W'(2));
    end
  end

  assign win_if.win_row = win_row_q;
  assign win_if.win_col = win_col_q;
`endif

endmodule

// File: tb/tb_laplace_cross_window.sv
// Bench for laplace_cross_window on a reduced 10x8 frame with the
// img[r][c] = (3r+c) mod 256 pattern; expected windows come from that
// formula and are queued per accepted pixel.
module tb_laplace_cross_window;
  import laplace_pkg::*;

  localparam int unsigned TW     = 10;
  localparam int unsigned TH     = 8;
  localparam int unsigned TROW_W = $clog2(TH);
  localparam int unsigned TCOL_W = $clog2(TW);
  localparam int          NWIN   = int'(win_count(TW, TH));
  localparam int          FIRST  = 2 * int'(TW) + 2;

  typedef struct {
    window_t w;
    logic    last;
    int      r;
    int      c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  laplace_cross_window_if #(.IMG_W(TW), .IMG_H(TH)) bus ();

  laplace_cross_window #(.IMG_W(TW), .IMG_H(TH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .win_if (bus)
  );

  exp_t    q[$];
  int      checks = 0;
  int      errors = 0;
  int      mr = 0;
  int      mc = 0;
  int      n_acc, n_win, n_done, first_win_at;
  window_t last_obs;
  window_t origin;

  function automatic pixel_t pix(input int r, input int c);
    return pixel_t'((3 * r + c) % 256);
  endfunction

  function automatic void mark();
    n_acc        = 0;
    n_win        = 0;
    n_done       = 0;
    first_win_at = -1;
  endfunction

  // One clock: drive a pixel (or idle), then check the registered result.
  task automatic step(input logic v, input logic s);
    exp_t    ex;
    window_t obs;
    int      rr, cc;
    @(negedge clk);
    bus.pix_valid = v;
    bus.sof       = s & v;
    if (v) begin
      rr = s ? 0 : mr;
      cc = s ? 0 : mc;
      bus.pix_in = pix(rr, cc);
      n_acc++;
      if (rr >= 2 && cc >= 2) begin
        ex.w    = '{b: pix(rr-2, cc-1), d: pix(rr-1, cc-2), e: pix(rr-1, cc-1),
                    f: pix(rr-1, cc),   h: pix(rr, cc-1)};
        ex.last = (rr == int'(TH) - 1) && (cc == int'(TW) - 1);
        ex.r    = rr - 2;
        ex.c    = cc - 2;
        q.push_back(ex);
      end
      if (cc == int'(TW) - 1) begin
        mc = 0;
        mr = (rr == int'(TH) - 1) ? 0 : rr + 1;
      end else begin
        mc = cc + 1;
        mr = rr;
      end
    end else begin
      bus.pix_in = pixel_t'($urandom);
    end
    @(posedge clk);
    #1;
    obs = '{b: bus.b, d: bus.d, e: bus.e, f: bus.f, h: bus.h};
    if (q.size() != 0) begin
      ex = q.pop_front();
      checks++;
      if (bus.win_valid !== 1'b1) begin
        errors++;
        $display("FAIL win_valid_missing (%0d,%0d): got %b want 1", ex.r, ex.c, bus.win_valid);
      end else begin
        n_win++;
        if (first_win_at < 0) first_win_at = n_acc - 1;
        checks++;
        if (obs !== ex.w) begin
          errors++;
          $display("FAIL window (%0d,%0d): got %h want %h", ex.r, ex.c, obs, ex.w);
        end
        if (ex.r == 0 && ex.c == 0) begin
          checks++;
          if (obs !== origin) begin
            errors++;
            $display("FAIL origin_window: got %h want %h", obs, origin);
          end
        end
      end
      checks++;
      if (bus.frame_done !== ex.last) begin
        errors++;
        $display("FAIL frame_done (%0d,%0d): got %b want %b", ex.r, ex.c, bus.frame_done, ex.last);
      end
      if (bus.frame_done === 1'b1) begin
        n_done++;
        checks++;
        if (bus.e !== pix(int'(TH) - 2, int'(TW) - 2)) begin
          errors++;
          $display("FAIL last_centre: got %h want %h", bus.e, pix(int'(TH) - 2, int'(TW) - 2));
        end
      end
`ifdef LAPLACE_WIN_COORD_EN
      checks++;
      if (bus.win_row !== TROW_W'(ex.r) || bus.win_col !== TCOL_W'(ex.c)) begin
        errors++;
        $display("FAIL win_coord: got (%0d,%0d) want (%0d,%0d)", bus.win_row, bus.win_col, ex.r, ex.c);
      end
`endif
      last_obs = ex.w;
    end else begin
      checks++;
      if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL spurious_strobe: got valid=%b done=%b want 0 0", bus.win_valid, bus.frame_done);
      end
      checks++;
      if (obs !== last_obs) begin
        errors++;
        $display("FAIL hold_window: got %h want %h", obs, last_obs);
      end
    end
  endtask

  task automatic run_frame(input bit gaps, input bit first_sof);
    for (int i = 0; i < int'(TW * TH); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) step(1'b0, 1'b0);
      end
      step(1'b1, first_sof && (i == 0));
    end
    step(1'b0, 1'b0);
  endtask

  task automatic check_counts(input string name, input int want_win, input int want_done,
                              input bit chk_first);
    checks++;
    if (n_win != want_win) begin
      errors++;
      $display("FAIL %s_win_count: got %0d want %0d", name, n_win, want_win);
    end
    checks++;
    if (n_done != want_done) begin
      errors++;
      $display("FAIL %s_done_count: got %0d want %0d", name, n_done, want_done);
    end
    if (chk_first) begin
      checks++;
      if (first_win_at != FIRST) begin
        errors++;
        $display("FAIL %s_first_window: got pixel %0d want %0d", name, first_win_at, FIRST);
      end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({bus.b, bus.d, bus.e, bus.f, bus.h} !== '0 || bus.win_valid !== 1'b0 ||
        bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_outputs_zero: got win=%h valid=%b done=%b want 0",
               name, {bus.b, bus.d, bus.e, bus.f, bus.h}, bus.win_valid, bus.frame_done);
    end
`ifdef LAPLACE_WIN_COORD_EN
    checks++;
    if (bus.win_row !== '0 || bus.win_col !== '0) begin
      errors++;
      $display("FAIL %s_coord_zero: got (%0d,%0d) want (0,0)", name, bus.win_row, bus.win_col);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    last_obs = '0;
    mr       = 0;
    mc       = 0;
  endtask

  task automatic test_full_frame();
    mark();
    run_frame(1'b0, 1'b1);
    check_counts("full", NWIN, 1, 1'b1);
  endtask

  task automatic test_gaps();
    mark();
    run_frame(1'b1, 1'b1);
    check_counts("gaps", NWIN, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    mark();
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b0);
    check_counts("b2b", 2 * NWIN, 2, 1'b1);
  endtask

  task automatic test_sof_mid();
    int guard;
    step(1'b1, 1'b1);
    guard = 0;
    while (!(mr == 5 && mc == 3) && guard < int'(TW * TH)) begin
      step(1'b1, 1'b0);
      guard++;
    end
    mark();
    for (int i = 0; i < int'(TW * TH); i++) step(1'b1, i == 0);
    step(1'b0, 1'b0);
    check_counts("sof_mid", NWIN, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int guard;
    step(1'b1, 1'b1);
    guard = 0;
    while (!(mr == 5 && mc == 4) && guard < int'(TW * TH)) begin
      step(1'b1, 1'b0);
      guard++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    q.delete();
    mr       = 0;
    mc       = 0;
    last_obs = '0;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    run_frame(1'b0, 1'b0);
    check_counts("after_reset", NWIN, 1, 1'b1);
  endtask

  initial begin
    origin = '{b: 8'd1, d: 8'd3, e: 8'd4, f: 8'd5, h: 8'd7};
    mark();
    test_reset();
    test_full_frame();
    test_gaps();
    test_back_to_back();
    test_sof_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
